// File: rtl/instr_loader.sv
// instr_loader: host-side writer for the core's 9-bit instruction memory.
// Accepts a byte-stream load frame {CNT_LO, CNT_HI, N x {LO, HI}, CHK} over a
// valid/ready handshake, unpacks it into instruction words and strobes them
// into the memory write port. The core is held until a complete program has
// been received and its XOR checksum verified.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   start     begin a new frame (honoured in IDLE/DONE/ERROR only)
//   inData    frame byte
//   inValid   inData valid
//   inReady   loader can accept a byte this cycle
//   wrEn      one-cycle write strobe per word
//   wrAddr    word address (word index k)
//   wrData    word data {HI[0], LO}
//   coreHold  high while the core must stay held (all states except DONE)
//   loadDone  program loaded and verified
//   loadError frame rejected
module instr_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   inData,
    input  logic         inValid,
    output logic         inReady,
    output logic         wrEn,
    output logic [D-1:0] wrAddr,
    output logic [W-1:0] wrData,
    output logic         coreHold,
    output logic         loadDone,
    output logic         loadError
);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_WORD_LO, S_WORD_HI, S_CHK, S_DONE, S_ERROR
    } state_t;

    // Largest legal word count is 2^D (fills the whole memory).
    localparam logic [16:0] MAX_N = 17'(1) << D;

    state_t      state, stateNext;
    logic [15:0] cnt;
    logic [D:0]  idx;        // one extra bit so N = 2^D can be reached without wrap
    logic [7:0]  loByte;
    logic [7:0]  chkSum;

    logic        xfer;
    logic        startAccept;
    logic        hiOk;
    logic [15:0] nFull;
    logic [D:0]  idxNext;

    assign inReady     = (state == S_CNT_LO) || (state == S_CNT_HI) ||
                         (state == S_WORD_LO) || (state == S_WORD_HI) ||
                         (state == S_CHK);
    assign coreHold    = (state != S_DONE);
    assign loadDone    = (state == S_DONE);
    assign loadError   = (state == S_ERROR);

    assign xfer        = inValid && inReady;
    assign startAccept = start && ((state == S_IDLE) || (state == S_DONE) ||
                                   (state == S_ERROR));
    assign hiOk        = (inData[7:1] == 7'd0);
    assign nFull       = {inData, cnt[7:0]};
    assign idxNext     = idx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR:
                if (start) stateNext = S_CNT_LO;
            S_CNT_LO:
                if (xfer) stateNext = S_CNT_HI;
            S_CNT_HI:
                if (xfer) begin
                    if ({1'b0, nFull} > MAX_N) stateNext = S_ERROR;
                    else if (nFull == 16'd0)   stateNext = S_CHK;
                    else                       stateNext = S_WORD_LO;
                end
            S_WORD_LO:
                if (xfer) stateNext = S_WORD_HI;
            S_WORD_HI:
                if (xfer) begin
                    if (!hiOk)                        stateNext = S_ERROR;
                    else if (16'(idxNext) == cnt)     stateNext = S_CHK;
                    else                              stateNext = S_WORD_LO;
                end
            S_CHK:
                if (xfer) stateNext = (inData == chkSum) ? S_DONE : S_ERROR;
            default: stateNext = S_IDLE;
        endcase
    end

    // Datapath. The write is registered, so the strobe lands in the cycle after
    // the HI byte while the next byte is already being accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            idx    <= '0;
            loByte <= '0;
            chkSum <= '0;
            wrEn   <= 1'b0;
            wrAddr <= '0;
            wrData <= '0;
        end else begin
            wrEn <= 1'b0;
            if (startAccept) begin
                chkSum <= '0;
                idx    <= '0;
                wrAddr <= '0;
            end
            if (xfer && (state != S_CHK))
                chkSum <= chkSum ^ inData;
            if (xfer) begin
                case (state)
                    S_CNT_LO:  cnt[7:0]  <= inData;
                    S_CNT_HI:  cnt[15:8] <= inData;
                    S_WORD_LO: loByte    <= inData;
                    S_WORD_HI:
                        if (hiOk) begin
                            wrEn   <= 1'b1;
                            wrAddr <= idx[D-1:0];
                            wrData <= W'({inData[0], loByte});
                            idx    <= idxNext;
                        end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
    localparam int D = 12;
    localparam int W = 9;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   inData = 8'h00;
    logic         inValid = 1'b0;
    logic         inReady, wrEn, coreHold, loadDone, loadError;
    logic [D-1:0] wrAddr;
    logic [W-1:0] wrData;

    always #5 clk = ~clk;

    instr_loader #(.D(D), .W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .inData(inData),
        .inValid(inValid), .inReady(inReady), .wrEn(wrEn), .wrAddr(wrAddr),
        .wrData(wrData), .coreHold(coreHold), .loadDone(loadDone),
        .loadError(loadError)
    );

    // Frame bytes packed MSB-first (byte 0 in the top used byte); expected
    // word data packed the same way, 9 bits per word.
    typedef struct {
        int          nb;
        logic [95:0] frm;
        int          nw;
        logic [35:0] wd;
        logic        expDone;
        logic        gap;
    } vec_t;

    vec_t        vecs[8];
    int          checks = 0;
    int          errors = 0;
    logic [20:0] sbq[$];     // {addr, data}
    logic [20:0] monExp;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard consumer: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (wrEn) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected write: addr %0h data %0h, expected none", wrAddr, wrData);
            end else begin
                monExp = sbq.pop_front();
                check("write", {11'd0, wrAddr, wrData}, {11'd0, monExp});
            end
        end
    end

    task automatic sendByte(input logic [7:0] b);
        int t = 0;
        inData  = b;
        inValid = 1'b1;
        while (!inReady && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!inReady) begin
            checks++;
            errors++;
            $display("FAIL sendByte timeout: inReady 0, required 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic doStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start inReady", inReady, 1);
    endtask

    task automatic runVec(input vec_t v, input int id);
        logic [8:0] last;
        doStart();
        last = 9'h0;
        for (int k = 0; k < v.nw; k++) begin
            last = v.wd[9*(v.nw-1-k) +: 9];
            sbq.push_back({12'(k), last});
        end
        for (int j = 0; j < v.nb; j++) begin
            sendByte(v.frm[8*(v.nb-1-j) +: 8]);
            if (v.gap) begin
                inValid = 1'b0;
                inData  = 8'hEE;
                @(posedge clk); #1;
            end
        end
        inValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("vec%0d done=%0b err=%0b", id, loadDone, loadError);
        check("loadDone", loadDone, v.expDone);
        check("loadError", loadError, !v.expDone);
        check("coreHold", coreHold, !v.expDone);
        check("inReady end", inReady, 0);
        check("writes left", sbq.size(), 0);
        check("wrAddr hold", wrAddr, (v.nw > 0) ? v.nw - 1 : 0);
        if (v.nw > 0) check("wrData hold", wrData, last);
    endtask

    initial begin
        logic [7:0] cs;
        logic [8:0] d;

        vecs[0] = '{9, 96'h0300FF010000A50058, 3, {9'h0, 9'h1FF, 9'h000, 9'h0A5}, 1'b1, 1'b0};
        vecs[1] = '{3, 96'h000000,             0, 36'h0,                            1'b1, 1'b0};
        vecs[2] = '{4, 96'h01001202,           0, 36'h0,                            1'b0, 1'b0};
        vecs[3] = '{9, 96'h0300FF010000A50058, 3, {9'h0, 9'h1FF, 9'h000, 9'h0A5}, 1'b1, 1'b1};
        vecs[4] = '{9, 96'h0300FF010000A50059, 3, {9'h0, 9'h1FF, 9'h000, 9'h0A5}, 1'b0, 1'b0};
        vecs[5] = '{2, 96'h0110,               0, 36'h0,                            1'b0, 1'b0};
        vecs[6] = '{5, 96'h0100340134,         1, {27'h0, 9'h134},                  1'b1, 1'b0};
        vecs[7] = '{7, 96'h020080017F01FD,     2, {18'h0, 9'h180, 9'h17F},          1'b1, 1'b0};

        // Reset state
        #3;
        check("rst inReady", inReady, 0);
        check("rst wrEn", wrEn, 0);
        check("rst wrAddr", wrAddr, 0);
        check("rst wrData", wrData, 0);
        check("rst loadDone", loadDone, 0);
        check("rst loadError", loadError, 0);
        check("rst coreHold", coreHold, 1);
        #9 reset = 1'b1;
        @(posedge clk); #1;
        check("idle inReady", inReady, 0);

        for (int i = 0; i < 8; i++) runVec(vecs[i], i);

        // inValid while DONE: nothing accepted, state held
        inValid = 1'b1;
        inData  = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        inValid = 1'b0;
        check("done hold loadDone", loadDone, 1);
        check("done hold inReady", inReady, 0);

        // start pulsed mid-frame must be ignored
        doStart();
        sbq.push_back({12'd0, 9'h134});
        sendByte(8'h01);
        sendByte(8'h00);
        inValid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sendByte(8'h34);
        sendByte(8'h01);
        sendByte(8'h34);
        inValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("start ignored done", loadDone, 1);
        check("start ignored writes", sbq.size(), 0);

        // Maximum count: N = 4096 fills addresses 0..0xFFF
        doStart();
        sendByte(8'h00);
        sendByte(8'h10);
        cs = 8'h10;
        for (int k = 0; k < 4096; k++) begin
            d = 9'(k * 37 + 5);
            sbq.push_back({12'(k), d});
            sendByte(d[7:0]);
            sendByte({7'd0, d[8]});
            cs = cs ^ d[7:0] ^ {7'd0, d[8]};
        end
        inValid = 1'b0;
        @(posedge clk); #1;
        check("max in CHK inReady", inReady, 1);
        check("max in CHK loadDone", loadDone, 0);
        check("max in CHK loadError", loadError, 0);
        check("max writes left", sbq.size(), 0);
        check("max last wrAddr", wrAddr, 12'hFFF);
        sendByte(cs);
        inValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("max loadDone", loadDone, 1);

        // Reset between words 1 and 2: immediate, no clock edge needed
        doStart();
        sbq.push_back({12'd0, 9'h1FF});
        sbq.push_back({12'd1, 9'h000});
        sendByte(8'h03);
        sendByte(8'h00);
        sendByte(8'hFF);
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h00);
        inValid = 1'b0;
        @(posedge clk); #2;
        check("pre-rst wrAddr", wrAddr, 1);
        reset = 1'b0;
        #1;
        check("midrst inReady", inReady, 0);
        check("midrst wrEn", wrEn, 0);
        check("midrst wrAddr", wrAddr, 0);
        check("midrst wrData", wrData, 0);
        check("midrst loadDone", loadDone, 0);
        check("midrst loadError", loadError, 0);
        check("midrst coreHold", coreHold, 1);
        check("midrst writes left", sbq.size(), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        inValid = 1'b1;
        inData  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        inValid = 1'b0;
        check("post-rst idle inReady", inReady, 0);
        check("post-rst coreHold", coreHold, 1);

        // Fresh frame after reset still loads
        runVec(vecs[0], 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name:
instr_loader

Overview:
- Host-side writer for the core's instruction memory: the fetch path only reads 9-bit machine code by PC, and this block fills that memory.
- Receives a byte-stream load frame over a valid/ready handshake and unpacks it into 9-bit instruction words.
- Issues single-cycle write strobes to the instruction memory write port.
- Holds the core (coreHold) until a complete, checksum-verified program is resident.

Parameters:
D, 12, instruction address width (matches PC width)
W, 9, instruction word width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a new load frame; honoured in IDLE, DONE, ERROR only
inData  input  8  frame byte
inValid  input  1  inData valid
inReady  output  1  loader can accept a byte; transfer = inValid && inReady at clk rise
wrEn  output  1  instruction memory write strobe, one cycle per word
wrAddr  output  D  write address
wrData  output  W  write data
coreHold  output  1  high = core must stay held
loadDone  output  1  level; program loaded and verified
loadError  output  1  level; frame rejected

Behaviour:
- Single clock domain. reset is asynchronous and active-low; all state is registered.
- Reset (asserted at any time, including mid-frame) takes effect immediately:
  - state=IDLE; inReady=0, wrEn=0, wrAddr=0, wrData=0, loadDone=0, loadError=0, coreHold=1.
  - Words already written stay in memory; no rollback.
- Frame byte order: CNT_LO, CNT_HI, then N pairs {LO, HI}, then CHK.
  - N = {CNT_HI, CNT_LO}, 16 bits.
  - Word k = {HI[0], LO[7:0]}, written to address k.
  - CHK = XOR of every preceding frame byte.
- States: IDLE, CNT_LO, CNT_HI, WORD_LO, WORD_HI, CHK, DONE, ERROR.
- inReady=1 exactly in CNT_LO, CNT_HI, WORD_LO, WORD_HI, CHK; 0 elsewhere.
- Throughput: one byte per cycle when inValid is held high. Gaps (inValid=0) leave the state unchanged. inData is ignored when no transfer occurs.
- coreHold = 1 in every state except DONE.
- IDLE/DONE/ERROR, start=1:
  - Next cycle: state=CNT_LO.
  - Clear the running checksum, word index, loadDone and loadError.
  - Clear wrAddr to 0.
- start is ignored in all receiving states.
- CNT_LO transfer: latch N[7:0] -> CNT_HI.
- CNT_HI transfer: latch N[15:8]. Then:
  - N > 2^D -> ERROR.
  - N == 0 -> CHK.
  - Otherwise -> WORD_LO.
- WORD_LO transfer: latch LO -> WORD_HI.
- WORD_HI transfer:
  - HI[7:1] != 0 -> ERROR; no write issued for this word.
  - Otherwise, in the following cycle: wrEn=1 for exactly one cycle, wrAddr = index, wrData = {HI[0], LO}.
  - Then index increments. If the new index == N -> CHK, else -> WORD_LO.
  - Index counter is D+1 bits, so N = 2^D is legal. The last write goes to address 2^D-1, with no wrap.
- The registered write overlaps acceptance of the next byte; no stall is required.
- Running checksum updates on every transfer except CHK. It includes the header and all word bytes.
- CHK transfer:
  - byte == running XOR -> DONE.
  - Otherwise -> ERROR. Words already written remain.
- DONE: loadDone=1, coreHold=0, inReady=0.
- ERROR: loadError=1, coreHold=1, inReady=0.
- Between writes, wrAddr/wrData hold the last written values. wrEn is never high in IDLE, DONE or ERROR, except the final write strobe cycle, which may coincide with entry to CHK.
- inValid asserted while inReady=0: no transfer, no state change.

Test Plan:
- Nominal load:
  - Stimulus: start; bytes 03 00 FF 01 00 00 A5 00 58.
  - Response: wrEn pulses at addr 0, 1, 2 with data 0x1FF, 0x000, 0x0A5; then loadDone=1, coreHold=0, inReady=0.
- Empty program:
  - Stimulus: start; bytes 00 00 00.
  - Response: no wrEn; DONE after the third byte; coreHold=0.
- Bad high byte:
  - Stimulus: start; bytes 01 00 12 02.
  - Response: ERROR after the 4th byte; no wrEn; loadError=1, coreHold=1. A new start plus a valid frame then reaches DONE.
- Checksum mismatch:
  - Stimulus: nominal frame with CHK=59.
  - Response: all 3 writes occur; then ERROR, coreHold=1.
- Oversize count and max count:
  - Stimulus: header 01 10 (N = 0x1001).
  - Response: ERROR right after CNT_HI; no writes.
  - Stimulus: header 00 10 (N = 4096).
  - Response: 4096 writes; last wrAddr = 0xFFF; then CHK.
- Gaps and reset mid-load:
  - Stimulus: nominal frame with inValid toggled every other cycle.
  - Response: identical writes and result.
  - Stimulus: assert reset between words 1 and 2.
  - Response: outputs take reset values immediately, without a clock edge; state IDLE; coreHold=1.
